// File: rtl/if3_out_skid_reg.sv
// if3_out_skid_reg: IF3 -> instruction-buffer register with valid/ready handshake and 2-entry skid (IF3_OUT_COMPACT_EN compacts valid lanes on enqueue)
module if3_out_skid_reg #(
    parameter int LANES  = 2,
    parameter int INST_W = 32,
    parameter int PC_W   = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_flush,
    input  logic                    i_pause,
    input  logic [LANES-1:0]        i_in_valid,
    input  logic [LANES*INST_W-1:0] i_in_inst,
    input  logic [LANES*PC_W-1:0]   i_in_pc,
    output logic                    o_in_ready,
    output logic [LANES-1:0]        o_out_valid,
    output logic [LANES*INST_W-1:0] o_out_inst,
    output logic [LANES*PC_W-1:0]   o_out_pc,
    input  logic                    i_out_ready
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t                  r_state, w_state_nxt;
    logic [LANES-1:0]        r_h_valid, r_s_valid, w_c_valid;
    logic [LANES*INST_W-1:0] r_h_inst, r_s_inst, w_c_inst;
    logic [LANES*PC_W-1:0]   r_h_pc, r_s_pc, w_c_pc;
    logic                    w_in_fire, w_out_fire, w_load_h_in, w_load_h_s, w_load_s;
    assign o_in_ready  = (r_state != FULL);
    assign o_out_valid = (r_state != EMPTY) ? r_h_valid : '0;
    assign o_out_inst  = r_h_inst;
    assign o_out_pc    = r_h_pc;
    assign w_in_fire   = |i_in_valid & o_in_ready;
    assign w_out_fire  = |o_out_valid & i_out_ready & ~i_pause;
`ifdef IF3_OUT_COMPACT_EN
    // pack valid lanes toward lane 0 in arrival order, zero the rest
    always_comb begin : compact
        int k;
        w_c_valid = '0;
        w_c_inst  = '0;
        w_c_pc    = '0;
        k = 0;
        for (int i = 0; i < LANES; i++) begin
            if (i_in_valid[i]) begin
                w_c_valid[k]                = 1'b1;
                w_c_inst[k*INST_W +: INST_W] = i_in_inst[i*INST_W +: INST_W];
                w_c_pc[k*PC_W +: PC_W]       = i_in_pc[i*PC_W +: PC_W];
                k++;
            end
        end
    end
`else
    assign w_c_valid = i_in_valid;
    assign w_c_inst  = i_in_inst;
    assign w_c_pc    = i_in_pc;
`endif
    // next state and storage load selects; flush overrides everything
    always_comb begin
        w_state_nxt = r_state;
        w_load_h_in = 1'b0;
        w_load_h_s  = 1'b0;
        w_load_s    = 1'b0;
        case (r_state)
            EMPTY: begin
                w_state_nxt = w_in_fire ? ONE : EMPTY;
                w_load_h_in = w_in_fire;
            end
            ONE: begin
                w_state_nxt = (w_in_fire && !w_out_fire) ? FULL : (!w_in_fire && w_out_fire) ? EMPTY : ONE;
                w_load_h_in = w_in_fire & w_out_fire;
                w_load_s    = w_in_fire & ~w_out_fire;
            end
            FULL: begin
                w_state_nxt = w_out_fire ? ONE : FULL;
                w_load_h_s  = w_out_fire;
            end
            default: w_state_nxt = EMPTY;
        endcase
        if (i_flush) begin
            w_state_nxt = EMPTY;
            w_load_h_in = 1'b0;
            w_load_h_s  = 1'b0;
            w_load_s    = 1'b0;
        end
    end
    // state register
    always_ff @(posedge i_clk) begin
        r_state <= i_rst ? EMPTY : w_state_nxt;
    end
    // head and skid storage
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_h_valid <= '0;
            r_h_inst  <= '0;
            r_h_pc    <= '0;
            r_s_valid <= '0;
            r_s_inst  <= '0;
            r_s_pc    <= '0;
        end else if (i_flush) begin
            r_h_valid <= '0;
            r_s_valid <= '0;
        end else begin
            if (w_load_h_in) begin
                r_h_valid <= w_c_valid;
                r_h_inst  <= w_c_inst;
                r_h_pc    <= w_c_pc;
            end else if (w_load_h_s) begin
                r_h_valid <= r_s_valid;
                r_h_inst  <= r_s_inst;
                r_h_pc    <= r_s_pc;
            end
            if (w_load_s) begin
                r_s_valid <= w_c_valid;
                r_s_inst  <= w_c_inst;
                r_s_pc    <= w_c_pc;
            end
        end
    end
endmodule
